// File: rtl/sysbus_pkg.sv
// Shared types and memory-map defaults for the system-bus decoder.
// Tag index width is fixed here, so decoders must have N_SLV <= 2**SB_IDX_W.
package sysbus_pkg;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SB_N_SLV = 4;
  localparam int SB_IDX_W = idx_w(SB_N_SLV);

  localparam logic [3:0] SB_BASE_DMEM   = 4'h0;
  localparam logic [3:0] SB_BASE_AUX    = 4'h1;
  localparam logic [3:0] SB_BASE_PERIPH = 4'h8;
  localparam logic [3:0] SB_BASE_GEMM   = 4'h9;

  typedef logic [SB_IDX_W-1:0] sb_idx_t;

  typedef struct packed {
    logic    v;
    logic    err;
    sb_idx_t idx;
  } sb_tag_t;

endpackage

// File: rtl/sysbus_if.sv
// System-bus signal bundle: master request/response side and fanned-out slave side.
interface sysbus_if #(
  parameter int N_SLV = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  logic              m_en;
  logic              m_rdwr;
  logic [AW-1:0]     m_addr;
  logic [DW-1:0]     m_wr_data;
  logic [DW/8-1:0]   m_mask;
  logic [DW-1:0]     m_rd_data;
  logic              m_rd_valid;
  logic              m_err;

  logic [N_SLV-1:0]    s_en;
  logic                s_rdwr;
  logic [AW-1:0]       s_addr;
  logic [DW-1:0]       s_wr_data;
  logic [DW/8-1:0]     s_mask;
  logic [N_SLV*DW-1:0] s_rd_data;

  modport master (
    output m_en, m_rdwr, m_addr, m_wr_data, m_mask,
    input  m_rd_data, m_rd_valid, m_err
  );

  modport slave (
    input  s_en, s_rdwr, s_addr, s_wr_data, s_mask,
    output s_rd_data
  );

  modport decoder (
    input  m_en, m_rdwr, m_addr, m_wr_data, m_mask,
    output m_rd_data, m_rd_valid, m_err,
    output s_en, s_rdwr, s_addr, s_wr_data, s_mask,
    input  s_rd_data
  );
endinterface

// File: rtl/sysbus_tag_pipe.sv
// Shift register of response tags matching the slave read latency.
// Clear only drops the valid bits; err/idx are don't-care while invalid.
module sysbus_tag_pipe
  import sysbus_pkg::*;
#(
  parameter int STAGES = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  sb_tag_t i_tag,
  output sb_tag_t o_tag
);

  sb_tag_t r_pipe [STAGES];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < STAGES; i++) r_pipe[i].v <= 1'b0;
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < STAGES; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_tag = r_pipe[STAGES-1];

endmodule

// File: rtl/sysbus_decoder.sv
// Address decoder and return mux between one bus master and N_SLV slaves,
// with error flagging for unmapped and read-only-write accesses.
module sysbus_decoder
  import sysbus_pkg::*;
#(
  parameter int                  N_SLV    = 4,
  parameter int                  AW       = 32,
  parameter int                  DW       = 32,
  parameter int                  RB       = 4,
  parameter int                  SLV_LAT  = 1,
  parameter logic [N_SLV*RB-1:0] SLV_BASE = {SB_BASE_GEMM, SB_BASE_PERIPH, SB_BASE_AUX, SB_BASE_DMEM},
  parameter logic [N_SLV-1:0]    SLV_RO   = '0,
  parameter logic [DW-1:0]       ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic          clk,
  input  logic          rst,
  sysbus_if.decoder     bus,
  output logic [15:0]   err_cnt,
  output logic [AW-1:0] last_err_addr
);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic          w_hit;
  sb_idx_t       w_idx;
  logic          w_err_req;
  sb_tag_t       w_tag_in;
  sb_tag_t       w_tail;
  logic [DW-1:0] w_slv_data;

  logic [DW-1:0] r_rd_data;
  logic          r_rd_valid;
  logic          r_err;
  logic [15:0]   r_err_cnt;
  logic [AW-1:0] r_last_err_addr;

  // Descending scan so the lowest matching index is the one left standing
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = N_SLV-1; i >= 0; i--) begin
      if (bus.m_addr[AW-1 -: RB] == SLV_BASE[i*RB +: RB]) begin
        w_hit = 1'b1;
        w_idx = sb_idx_t'(i);
      end
    end
  end

  assign w_err_req = bus.m_en & (~w_hit | (bus.m_rdwr & SLV_RO[w_idx]));

  always_comb begin
    bus.s_en = '0;
    for (int i = 0; i < N_SLV; i++)
      bus.s_en[i] = bus.m_en & w_hit & (w_idx == sb_idx_t'(i)) & ~(bus.m_rdwr & SLV_RO[i]);
  end

  assign bus.s_rdwr    = bus.m_rdwr;
  assign bus.s_addr    = {bus.m_addr[AW-1:2], 2'b00};
  assign bus.s_wr_data = bus.m_wr_data;
  assign bus.s_mask    = bus.m_mask;

  // Errored requests select no slave, so idx[0] is reused to remember write vs read
  always_comb begin
    w_tag_in.v   = bus.m_en & (~bus.m_rdwr | w_err_req);
    w_tag_in.err = w_err_req;
    w_tag_in.idx = w_err_req ? sb_idx_t'(bus.m_rdwr) : w_idx;
  end

  sysbus_tag_pipe #(.STAGES(SLV_LAT)) u_tags (
    .clk   (clk),
    .rst   (rst),
    .i_tag (w_tag_in),
    .o_tag (w_tail)
  );

  assign w_slv_data = bus.s_rd_data[int'(w_tail.idx)*DW +: DW];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rd_valid <= w_tail.v & (~w_tail.err | ~w_tail.idx[0]);
      r_err      <= w_tail.v & w_tail.err;
      if (w_tail.v & ~w_tail.err)         r_rd_data <= w_slv_data;
      else if (w_tail.v & ~w_tail.idx[0]) r_rd_data <= ERR_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_err_cnt       <= '0;
      r_last_err_addr <= '0;
    end else if (w_err_req) begin
      r_err_cnt       <= sat_inc(r_err_cnt);
      r_last_err_addr <= bus.m_addr;
    end
  end

  assign bus.m_rd_data  = r_rd_data;
  assign bus.m_rd_valid = r_rd_valid;
  assign bus.m_err      = r_err;
  assign err_cnt        = r_err_cnt;
  assign last_err_addr  = r_last_err_addr;

endmodule

// File: tb/tb_sysbus_decoder.sv
// Scoreboard bench: two decoders (latency 1 with slave 3 read-only, latency 3 writable).
module tb_sysbus_decoder;

  localparam logic [31:0] K = 32'hA5A5_A5A5;

  typedef struct {
    int          due;
    logic        vld;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst1, rst3;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t q1[$];
  exp_t q3[$];

  logic [15:0] ec1, ec3;
  logic [31:0] la1, la3;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sysbus_if #(.N_SLV(4), .AW(32), .DW(32)) b1 ();
  sysbus_if #(.N_SLV(4), .AW(32), .DW(32)) b3 ();

  sysbus_decoder #(.SLV_LAT(1), .SLV_RO(4'b1000)) dut1 (
    .clk(clk), .rst(rst1), .bus(b1), .err_cnt(ec1), .last_err_addr(la1)
  );

  sysbus_decoder #(.SLV_LAT(3), .SLV_RO(4'b0000)) dut3 (
    .clk(clk), .rst(rst3), .bus(b3), .err_cnt(ec3), .last_err_addr(la3)
  );

  // Slave models: return address ^ K, register only when enabled for a read
  logic [31:0] sd1 [4];
  logic [31:0] sp3 [4][3];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (b1.s_en[i] && !b1.s_rdwr) sd1[i] <= b1.s_addr ^ K;
      if (b3.s_en[i] && !b3.s_rdwr) sp3[i][0] <= b3.s_addr ^ K;
      sp3[i][1] <= sp3[i][0];
      sp3[i][2] <= sp3[i][1];
    end
  end

  assign b1.s_rd_data = {sd1[3], sd1[2], sd1[1], sd1[0]};
  assign b3.s_rd_data = {sp3[3][2], sp3[2][2], sp3[1][2], sp3[0][2]};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitors: pop on the due cycle, flag any unexpected output
  always @(negedge clk) begin
    if (q1.size() > 0 && q1[0].due == cyc) begin
      exp_t e;
      e = q1.pop_front();
      n_vec++;
      if (b1.m_rd_valid !== e.vld || b1.m_err !== e.err || (e.vld && b1.m_rd_data !== e.data)) begin
        n_bad++;
        $display("FAIL rsp1@%0d: got v=%b e=%b d=%h expected v=%b e=%b d=%h",
                 cyc, b1.m_rd_valid, b1.m_err, b1.m_rd_data, e.vld, e.err, e.data);
      end
    end else if (b1.m_rd_valid === 1'b1 || b1.m_err === 1'b1) begin
      n_vec++;
      n_bad++;
      $display("FAIL spurious1@%0d: got v=%b e=%b expected no response", cyc, b1.m_rd_valid, b1.m_err);
    end
  end

  always @(negedge clk) begin
    if (q3.size() > 0 && q3[0].due == cyc) begin
      exp_t e;
      e = q3.pop_front();
      n_vec++;
      if (b3.m_rd_valid !== e.vld || b3.m_err !== e.err || (e.vld && b3.m_rd_data !== e.data)) begin
        n_bad++;
        $display("FAIL rsp3@%0d: got v=%b e=%b d=%h expected v=%b e=%b d=%h",
                 cyc, b3.m_rd_valid, b3.m_err, b3.m_rd_data, e.vld, e.err, e.data);
      end
    end else if (b3.m_rd_valid === 1'b1 || b3.m_err === 1'b1) begin
      n_vec++;
      n_bad++;
      $display("FAIL spurious3@%0d: got v=%b e=%b expected no response", cyc, b3.m_rd_valid, b3.m_err);
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // One request cycle; called at posedge+1, returns at the next posedge+1
  task automatic req(input int u, input string nm, input logic rdwr, input logic [31:0] addr,
                     input logic [3:0] sen, input logic pv, input logic pe, input logic [31:0] pd);
    exp_t x;
    x.vld = pv; x.err = pe; x.data = pd;
    if (u == 1) begin
      b1.m_en = 1'b1; b1.m_rdwr = rdwr; b1.m_addr = addr;
      x.due = cyc + 2;
      if (pv || pe) q1.push_back(x);
    end else begin
      b3.m_en = 1'b1; b3.m_rdwr = rdwr; b3.m_addr = addr;
      x.due = cyc + 4;
      if (pv || pe) q3.push_back(x);
    end
    #1;
    chk({nm, "_s_en"}, (u == 1) ? {28'd0, b1.s_en} : {28'd0, b3.s_en}, {28'd0, sen});
    @(posedge clk);
    #1;
    if (u == 1) b1.m_en = 1'b0; else b3.m_en = 1'b0;
  endtask

  initial begin
    rst1 = 1'b0; rst3 = 1'b0;
    b1.m_en = 1'b0; b1.m_rdwr = 1'b0; b1.m_addr = '0; b1.m_wr_data = '0; b1.m_mask = '0;
    b3.m_en = 1'b0; b3.m_rdwr = 1'b0; b3.m_addr = '0; b3.m_wr_data = '0; b3.m_mask = '0;
    step(3);
    rst1 = 1'b1; rst3 = 1'b1;

    chk("rst_rd_data",  b1.m_rd_data, 32'h0);
    chk("rst_rd_valid", {31'd0, b1.m_rd_valid}, 32'h0);
    chk("rst_err",      {31'd0, b1.m_err}, 32'h0);
    chk("rst_err_cnt",  {16'd0, ec1}, 32'h0);
    chk("rst_last_err", la1, 32'h0);

    // Single read to DMEM
    req(1, "t1", 1'b0, 32'h0000_0010, 4'b0001, 1'b1, 1'b0, 32'hA5A5_A5B5);
    step(3);
    chk("t1_hold", b1.m_rd_data, 32'hA5A5_A5B5);

    // Back-to-back reads to slaves 3, 0, 2
    req(1, "t2a", 1'b0, 32'h9000_0004, 4'b1000, 1'b1, 1'b0, 32'h35A5_A5A1);
    req(1, "t2b", 1'b0, 32'h0000_0008, 4'b0001, 1'b1, 1'b0, 32'hA5A5_A5AD);
    req(1, "t2c", 1'b0, 32'h8000_000C, 4'b0100, 1'b1, 1'b0, 32'h25A5_A5A9);
    step(2);

    // Unaligned read: word address forced onto s_addr
    req(1, "algn", 1'b0, 32'h8000_0007, 4'b0100, 1'b1, 1'b0, 32'h25A5_A5A1);
    chk("algn_s_addr", b1.s_addr, 32'h8000_0004);
    step(2);

    // Write: no response
    b1.m_wr_data = 32'h1234_5678;
    b1.m_mask    = 4'b0011;
    req(1, "t3", 1'b1, 32'h0000_0020, 4'b0001, 1'b0, 1'b0, 32'h0);
    chk("t3_s_addr",    b1.s_addr, 32'h0000_0020);
    chk("t3_s_mask",    {28'd0, b1.s_mask}, 32'h3);
    chk("t3_s_wr_data", b1.s_wr_data, 32'h1234_5678);
    chk("t3_s_rdwr",    {31'd0, b1.s_rdwr}, 32'h1);
    step(1);
    chk("t3_no_valid", {31'd0, b1.m_rd_valid}, 32'h0);
    chk("t3_no_err",   {31'd0, b1.m_err}, 32'h0);
    step(1);

    // Unmapped read
    req(1, "t4", 1'b0, 32'h5000_0000, 4'b0000, 1'b1, 1'b1, 32'hDEAD_BEEF);
    chk("t4_err_cnt",  {16'd0, ec1}, 32'd1);
    chk("t4_last_err", la1, 32'h5000_0000);
    step(2);

    // Unmapped write: error pulse only, read data holds
    req(1, "uw", 1'b1, 32'h3000_0000, 4'b0000, 1'b0, 1'b1, 32'h0);
    chk("uw_err_cnt", {16'd0, ec1}, 32'd2);
    step(3);
    chk("uw_hold", b1.m_rd_data, 32'hDEAD_BEEF);

    // Writes to read-only slave 3, enough to saturate the counter
    req(1, "t5", 1'b1, 32'h9000_0000, 4'b0000, 1'b0, 1'b1, 32'h0);
    chk("t5_err_cnt", {16'd0, ec1}, 32'd3);
    for (int i = 1; i < 70000; i++)
      req(1, "t5r", 1'b1, 32'h9000_0000, 4'b0000, 1'b0, 1'b1, 32'h0);
    step(3);
    chk("t5_sat", {16'd0, ec1}, 32'h0000_FFFF);
    chk("t5_last_err", la1, 32'h9000_0000);

    // Latency-3 decoder: warm-up read, then reset while requests in flight
    req(3, "w3", 1'b0, 32'h8000_0000, 4'b0100, 1'b1, 1'b0, 32'h25A5_A5A5);
    step(5);
    req(3, "u3", 1'b1, 32'hF000_0000, 4'b0000, 1'b0, 1'b1, 32'h0);
    step(5);
    chk("w3_err_cnt", {16'd0, ec3}, 32'd1);
    req(3, "t6a", 1'b0, 32'h0000_0010, 4'b0001, 1'b0, 1'b0, 32'h0);
    rst3 = 1'b0;
    req(3, "t6r", 1'b0, 32'h0000_0040, 4'b0001, 1'b0, 1'b0, 32'h0);
    rst3 = 1'b1;
    chk("t6_rst_data",  b3.m_rd_data, 32'h0);
    chk("t6_rst_cnt",   {16'd0, ec3}, 32'h0);
    chk("t6_rst_last",  la3, 32'h0);
    step(6);
    req(3, "t6b", 1'b0, 32'h9000_0004, 4'b1000, 1'b1, 1'b0, 32'h35A5_A5A1);
    req(3, "t6w", 1'b1, 32'h9000_0008, 4'b1000, 1'b0, 1'b0, 32'h0);
    req(3, "t6u", 1'b0, 32'h2000_0000, 4'b0000, 1'b1, 1'b1, 32'hDEAD_BEEF);
    chk("t6_err_cnt", {16'd0, ec3}, 32'd1);

    for (int k = 0; k < 20 && (q1.size() > 0 || q3.size() > 0); k++) step(1);
    while (q1.size() > 0) begin
      n_vec++; n_bad++;
      $display("FAIL timeout1: got no response expected one due at %0d", q1[0].due);
      void'(q1.pop_front());
    end
    while (q3.size() > 0) begin
      n_vec++; n_bad++;
      $display("FAIL timeout3: got no response expected one due at %0d", q3[0].due);
      void'(q3.pop_front());
    end
    step(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
